// File: rtl/if_id_reg.sv
// F/D pipeline register: captures fetch PC/instruction, flags fetch address errors,
// records the branch-delay-slot bit and honours stall, exception request and eret flush.
module if_id_reg #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6ffc,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic        Req,
  input  logic        flush,
  input  logic [31:0] F_pc,
  input  logic [31:0] F_instr,
  input  logic        D_is_bj,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic [4:0]  D_exccode,
  output logic        D_bd,
  output logic        D_valid
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic [EXC_W-1:0] exccode;
    logic             bd;
    logic             valid;
  } d_stage_t;

  d_stage_t d_stage_q;
  d_stage_t d_stage_d;
  logic     adel_c;

  // Misaligned and out-of-range fetches collapse into one AdEL condition.
  assign adel_c = (F_pc[1:0] != 2'b00) || (F_pc < IM_LO) || (F_pc > IM_HI);

  // Next-state: Req > flush > WE > hold; bubbles never carry bd or an exception.
  always_comb begin
    d_stage_d = d_stage_q;
    if (Req) begin
      d_stage_d.pc      = HANDLER_PC;
      d_stage_d.instr   = '0;
      d_stage_d.exccode = '0;
      d_stage_d.bd      = 1'b0;
      d_stage_d.valid   = 1'b0;
    end else if (flush) begin
      d_stage_d.pc      = F_pc;
      d_stage_d.instr   = '0;
      d_stage_d.exccode = '0;
      d_stage_d.bd      = 1'b0;
      d_stage_d.valid   = 1'b0;
    end else if (WE) begin
      d_stage_d.pc      = F_pc;
      d_stage_d.instr   = adel_c ? '0 : F_instr;
      d_stage_d.exccode = adel_c ? EXC_ADEL : EXC_W'(0);
      d_stage_d.bd      = D_is_bj;
      d_stage_d.valid   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_stage_q.pc      <= PC_RESET;
      d_stage_q.instr   <= '0;
      d_stage_q.exccode <= '0;
      d_stage_q.bd      <= 1'b0;
      d_stage_q.valid   <= 1'b0;
    end else begin
      d_stage_q <= d_stage_d;
    end
  end

  assign D_pc      = d_stage_q.pc;
  assign D_instr   = d_stage_q.instr;
  assign D_exccode = d_stage_q.exccode;
  assign D_bd      = d_stage_q.bd;
  assign D_valid   = d_stage_q.valid;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for the F/D pipeline register.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        reset, WE, Req, flush, D_is_bj;
  logic [31:0] F_pc, F_instr;
  logic [31:0] D_pc, D_instr;
  logic [4:0]  D_exccode;
  logic        D_bd, D_valid;

  int errors = 0;
  int checks = 0;

  if_id_reg dut (
    .clk(clk), .reset(reset), .WE(WE), .Req(Req), .flush(flush),
    .F_pc(F_pc), .F_instr(F_instr), .D_is_bj(D_is_bj),
    .D_pc(D_pc), .D_instr(D_instr), .D_exccode(D_exccode),
    .D_bd(D_bd), .D_valid(D_valid)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; WE = 1'b1; Req = 1'b0; flush = 1'b0; D_is_bj = 1'b0;
    F_pc = 32'h0000_3000; F_instr = 32'h3c01_0001;
    step();
    checks++; if (D_pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", D_pc, 32'h3000); end
    checks++; if (D_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", D_valid); end
    checks++; if (D_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", D_instr); end
    checks++; if (D_bd !== 1'b0 || D_exccode !== 5'd0) begin errors++; $display("FAIL reset_bd_exc got=%b/%0d exp=0/0", D_bd, D_exccode); end
    reset = 1'b0;
    step();
    checks++; if (D_pc !== 32'h3000) begin errors++; $display("FAIL first_pc got=%h exp=%h", D_pc, 32'h3000); end
    checks++; if (D_instr !== 32'h3c01_0001) begin errors++; $display("FAIL first_instr got=%h exp=3c010001", D_instr); end
    checks++; if (D_exccode !== 5'd0) begin errors++; $display("FAIL first_exc got=%0d exp=0", D_exccode); end
    checks++; if (D_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", D_valid); end
  endtask

  task automatic test_adel();
    logic [31:0] pcs [4];
    logic [4:0]  excs [4];
    pcs  = '{32'h3002, 32'h2ffc, 32'h6ffc, 32'h7000};
    excs = '{5'd4, 5'd4, 5'd0, 5'd4};
    WE = 1'b1; F_instr = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      F_pc = pcs[i];
      step();
      checks++; if (D_exccode !== excs[i]) begin errors++; $display("FAIL adel_exc[%0d] got=%0d exp=%0d", i, D_exccode, excs[i]); end
      checks++;
      if (D_instr !== ((excs[i] != 5'd0) ? 32'h0 : 32'h1234_5678)) begin
        errors++; $display("FAIL adel_instr[%0d] got=%h", i, D_instr);
      end
      checks++; if (D_valid !== 1'b1 || D_pc !== pcs[i]) begin errors++; $display("FAIL adel_valid_pc[%0d] got=%b/%h exp=1/%h", i, D_valid, D_pc, pcs[i]); end
    end
  endtask

  task automatic test_bd_stall();
    WE = 1'b1; D_is_bj = 1'b1; F_pc = 32'h3010; F_instr = 32'haabb_ccdd;
    step();
    checks++; if (D_bd !== 1'b1) begin errors++; $display("FAIL bd_set got=%b exp=1", D_bd); end
    checks++; if (D_pc !== 32'h3010) begin errors++; $display("FAIL bd_pc got=%h exp=3010", D_pc); end
    WE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      D_is_bj = (i % 2 == 0) ? 1'b0 : 1'b1;
      F_pc = 32'h3100 + 32'(i * 4); F_instr = 32'h1111_0000 + 32'(i);
      step();
      checks++;
      if (D_pc !== 32'h3010 || D_instr !== 32'haabb_ccdd || D_bd !== 1'b1 || D_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d] got=%h/%h/%b/%b exp=3010/aabbccdd/1/1", i, D_pc, D_instr, D_bd, D_valid);
      end
    end
    D_is_bj = 1'b0;
  endtask

  task automatic test_req();
    WE = 1'b0; Req = 1'b1; F_pc = 32'h3020; F_instr = 32'h2222_2222;
    step();
    checks++;
    if (D_pc !== 32'h4180 || D_instr !== 32'h0 || D_bd !== 1'b0 || D_valid !== 1'b0) begin
      errors++; $display("FAIL req_stall got=%h/%h/%b/%b exp=4180/0/0/0", D_pc, D_instr, D_bd, D_valid);
    end
    Req = 1'b0; WE = 1'b1; D_is_bj = 1'b1; F_pc = 32'h3024;
    step();
    checks++; if (D_valid !== 1'b1 || D_pc !== 32'h3024) begin errors++; $display("FAIL req_reload got=%b/%h exp=1/3024", D_valid, D_pc); end
    Req = 1'b1; flush = 1'b1; WE = 1'b1; F_pc = 32'h3028;
    step();
    checks++;
    if (D_pc !== 32'h4180 || D_instr !== 32'h0 || D_bd !== 1'b0 || D_valid !== 1'b0) begin
      errors++; $display("FAIL req_flush_we got=%h/%h/%b/%b exp=4180/0/0/0", D_pc, D_instr, D_bd, D_valid);
    end
    Req = 1'b0; flush = 1'b0; D_is_bj = 1'b0;
  endtask

  task automatic test_flush();
    WE = 1'b1; F_pc = 32'h3002; F_instr = 32'h3333_3333;
    step();
    checks++; if (D_exccode !== 5'd4) begin errors++; $display("FAIL flush_pre_exc got=%0d exp=4", D_exccode); end
    flush = 1'b1; WE = 1'b0; F_pc = 32'h3040;
    step();
    checks++;
    if (D_pc !== 32'h3040 || D_instr !== 32'h0 || D_valid !== 1'b0 || D_exccode !== 5'd0) begin
      errors++; $display("FAIL flush got=%h/%h/%b/%0d exp=3040/0/0/0", D_pc, D_instr, D_valid, D_exccode);
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_req();
    WE = 1'b1; D_is_bj = 1'b1; F_pc = 32'h3050; F_instr = 32'h4444_4444;
    step();
    checks++; if (D_bd !== 1'b1 || D_valid !== 1'b1) begin errors++; $display("FAIL rr_pre got=%b/%b exp=1/1", D_bd, D_valid); end
    reset = 1'b1; Req = 1'b1; WE = 1'b0;
    step();
    checks++;
    if (D_pc !== 32'h3000 || D_bd !== 1'b0 || D_valid !== 1'b0 || D_exccode !== 5'd0 || D_instr !== 32'h0) begin
      errors++; $display("FAIL reset_req got=%h/%b/%b/%0d exp=3000/0/0/0", D_pc, D_bd, D_valid, D_exccode);
    end
    reset = 1'b0; Req = 1'b0; D_is_bj = 1'b0;
  endtask

  initial begin
    test_reset();
    test_adel();
    test_bd_stall();
    test_req();
    test_flush();
    test_reset_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
